// File: rtl/i2c_eeprom_responder.sv
// I2C target emulating a 256-byte EEPROM: oversampled bus decode, open-drain SDA enable,
// and a synchronous 256x8 memory port with an auto-incrementing address pointer.
`timescale 1ns/1ps

module i2c_eeprom_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  output logic       mem_re,
  input  logic [7:0] mem_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_DEV_ACK,
    S_REG_ADDR,
    S_REG_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_WAIT_STOP
  } state_t;

  state_t     r_state;
  logic [1:0] r_sclSync;
  logic [1:0] r_sdaSync;
  logic       r_sclDly;
  logic       r_sdaDly;
  logic [7:0] r_shift;
  logic [2:0] r_bitCnt;
  logic [7:0] r_pointer;
  logic       r_rw;
  logic       r_rdLoad;
  logic       r_sdaOe;
  logic [7:0] r_memAddr;
  logic       r_memWe;
  logic [7:0] r_memWdata;
  logic       r_memRe;
  logic       r_busy;

  logic       w_scl;
  logic       w_sda;
  logic       w_sclRise;
  logic       w_sclFall;
  logic       w_start;
  logic       w_stop;
  logic       w_lastBit;
  logic [7:0] w_byte;

  // Synchroniser flops reset to the idle-high bus level so reset release never looks like an event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclSync <= 2'b11;
      r_sdaSync <= 2'b11;
      r_sclDly  <= 1'b1;
      r_sdaDly  <= 1'b1;
    end else begin
      r_sclSync <= {r_sclSync[0], scl_i};
      r_sdaSync <= {r_sdaSync[0], sda_i};
      r_sclDly  <= r_sclSync[1];
      r_sdaDly  <= r_sdaSync[1];
    end
  end

  assign w_scl     = r_sclSync[1];
  assign w_sda     = r_sdaSync[1];
  assign w_sclRise = w_scl & ~r_sclDly;
  assign w_sclFall = ~w_scl & r_sclDly;
  assign w_start   = w_scl & r_sclDly & r_sdaDly & ~w_sda;
  assign w_stop    = w_scl & r_sclDly & ~r_sdaDly & w_sda;
  assign w_lastBit = (r_bitCnt == 3'd7);
  assign w_byte    = {r_shift[6:0], w_sda};

  // ACK states are entered on the 8th rising edge, pull SDA on the following fall, and exit on the 9th rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_shift    <= 8'h00;
      r_bitCnt   <= 3'd0;
      r_pointer  <= 8'h00;
      r_rw       <= 1'b0;
      r_rdLoad   <= 1'b0;
      r_sdaOe    <= 1'b0;
      r_memAddr  <= 8'h00;
      r_memWe    <= 1'b0;
      r_memWdata <= 8'h00;
      r_memRe    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_memWe  <= 1'b0;
      r_memRe  <= 1'b0;
      r_rdLoad <= r_memRe;
      // Read data arrives the cycle after the strobe; it is captured well before the next SCL fall.
      if (r_rdLoad) begin
        r_shift <= mem_rdata;
      end
      if (w_stop) begin
        r_state <= S_IDLE;
        r_sdaOe <= 1'b0;
        r_busy  <= 1'b0;
      end else if (w_start) begin
        r_state  <= S_DEV_ADDR;
        r_bitCnt <= 3'd0;
        r_sdaOe  <= 1'b0;
      end else if (w_sclRise) begin
        case (r_state)
          S_DEV_ADDR: begin
            r_shift  <= w_byte;
            r_bitCnt <= r_bitCnt + 3'd1;
            if (w_lastBit) begin
              if (w_byte[7:1] == DEV_ADDR) begin
                r_state <= S_DEV_ACK;
                r_busy  <= 1'b1;
                r_rw    <= w_byte[0];
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
          S_DEV_ACK: begin
            r_bitCnt <= 3'd0;
            if (r_rw) begin
              r_memRe   <= 1'b1;
              r_memAddr <= r_pointer;
              r_state   <= S_RD_DATA;
            end else begin
              r_state <= S_REG_ADDR;
            end
          end
          S_REG_ADDR: begin
            r_shift  <= w_byte;
            r_bitCnt <= r_bitCnt + 3'd1;
            if (w_lastBit) begin
              r_pointer <= w_byte;
              r_state   <= S_REG_ACK;
            end
          end
          S_REG_ACK, S_WR_ACK: begin
            r_bitCnt <= 3'd0;
            r_state  <= S_WR_DATA;
          end
          S_WR_DATA: begin
            r_shift  <= w_byte;
            r_bitCnt <= r_bitCnt + 3'd1;
            if (w_lastBit) begin
              r_memWe    <= 1'b1;
              r_memAddr  <= r_pointer;
              r_memWdata <= w_byte;
              r_pointer  <= r_pointer + 8'd1;
              r_state    <= S_WR_ACK;
            end
          end
          S_RD_DATA: begin
            r_shift  <= {r_shift[6:0], 1'b0};
            r_bitCnt <= r_bitCnt + 3'd1;
            if (w_lastBit) begin
              r_pointer <= r_pointer + 8'd1;
              r_state   <= S_RD_ACK;
            end
          end
          S_RD_ACK: begin
            if (!w_sda) begin
              r_memRe   <= 1'b1;
              r_memAddr <= r_pointer;
              r_bitCnt  <= 3'd0;
              r_state   <= S_RD_DATA;
            end else begin
              r_state <= S_WAIT_STOP;
            end
          end
          default: begin
          end
        endcase
      end else if (w_sclFall) begin
        case (r_state)
          S_DEV_ACK, S_REG_ACK, S_WR_ACK: r_sdaOe <= 1'b1;
          S_RD_DATA:                      r_sdaOe <= ~r_shift[7];
          default:                        r_sdaOe <= 1'b0;
        endcase
      end
    end
  end

  assign sda_oe    = r_sdaOe;
  assign mem_addr  = r_memAddr;
  assign mem_we    = r_memWe;
  assign mem_wdata = r_memWdata;
  assign mem_re    = r_memRe;
  assign busy      = r_busy;

endmodule

// File: doc/i2c_eeprom_responder.md
Name: i2c_eeprom_responder

Overview:
- Standalone I2C target (responder) emulating a 256-byte EEPROM; counterpart to the team's I2C master.
- Oversamples SCL/SDA on the system clock and decodes START/STOP, device address, register address and data.
- Drives SDA open-drain through an enable, and fronts an external 256x8 synchronous memory port.
- Used as a bus-functional EEPROM in the i2c_eeprom subsystem and as a reusable target in SoC tops.

Parameters:
- DEV_ADDR, 7'h50, 7-bit device address answered by this target.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- scl_i  input  1  bus SCL, asynchronous to clk.
- sda_i  input  1  bus SDA as seen on the pad, asynchronous to clk.
- sda_oe  output  1  1 = pull SDA low; 0 = release SDA (pad pulls high).
- mem_addr  output  8  memory address (address pointer).
- mem_we  output  1  one-clk write strobe.
- mem_wdata  output  8  write data, valid with mem_we.
- mem_re  output  1  one-clk read strobe.
- mem_rdata  input  8  read data, valid exactly 1 clk after mem_re.
- busy  output  1  high from an address-matched START until STOP, or until a return to IDLE.

Behaviour:
- Reset values: sda_oe=0, mem_we=0, mem_re=0, mem_addr=8'h00, mem_wdata=8'h00, busy=0, state=IDLE, pointer=0.
- Reset takes effect immediately, including mid-transfer; SDA is released at once.
- Input synchronisation: scl_i and sda_i each pass through 2 flops, then a third flop provides edge detection.
- Timing requirement: SCL high and low phases are each >= 8 clk.
- Bus event decode:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Data bits are sampled on SCL rising edges.
  - sda_oe changes only on SCL falling edges, 1 clk after detection.
- START or repeated START in any state: go to DEV_ADDR, clear the bit counter, release SDA.
- STOP in any state: go to IDLE, release SDA, drop busy. A partial byte in progress is discarded (no mem_we).
- State machine:
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits MSB first. If bits[7:1] != DEV_ADDR, go to IDLE with no ACK; otherwise go to DEV_ACK and set busy.
  - DEV_ACK: drive ACK (sda_oe=1) for one SCL period, released on the next falling edge.
    - R/W=0: go to REG_ADDR.
    - R/W=1: pulse mem_re (mem_addr=pointer) on the ACK rising edge, load the shift register from mem_rdata 1 clk later, go to RD_DATA.
  - REG_ADDR: shift 8 bits, load pointer, go to REG_ACK (ACK) and then WR_DATA.
  - WR_DATA: shift 8 bits.
    - On the 8th rising edge: mem_we pulses for 1 clk with mem_addr=pointer and mem_wdata=the byte.
    - Pointer increments after the write, wrapping 8'hFF to 8'h00.
    - Go to WR_ACK (ACK), then back to WR_DATA.
  - RD_DATA: drive 8 bits MSB first; sda_oe = ~bit. Go to RD_ACK after the 8th bit.
    - Pointer increments after each byte read, with wrap.
  - RD_ACK: SDA released; sample the master's bit on the rising edge.
    - 0 (ACK): pulse mem_re at the new pointer, reload the shift register, go to RD_DATA.
    - 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP (to IDLE) or START (to DEV_ADDR).
- Random read: write dev address + reg address, repeated START, then dev address with R/W=1, then read.
- Current-address read: START, then dev address with R/W=1, reading from the existing pointer.
- No clock stretching; sda_oe is never asserted while SCL is high except during ACK/data hold of the current bit.

Test Plan:
- Byte write to 0x50, reg 0x3C, data 0xA5, then STOP -> each of the three bytes ACKed; mem_we=1 for exactly 1 clk with mem_addr=0x3C, mem_wdata=0xA5; busy=0 after STOP.
- Sequential write at reg 0xFE, data 0x11, 0x22, 0x33 -> writes 0xFE=0x11, 0xFF=0x22, 0x00=0x33 (wrap); final pointer=0x01.
- Random read of reg 0x10, memory model returning 0x5A then 0x6B, master ACKs the first byte and NACKs the second -> bus shows 0x5A then 0x6B; mem_re at 0x10 then 0x11; state WAIT_STOP until STOP.
- Address 0x51 write -> no ACK (SDA released in the 9th clock); busy stays 0; no mem_we/mem_re.
- STOP after 4 data bits of a write byte -> no mem_we; state IDLE; sda_oe=0.
- reset_n low during RD_DATA while driving a 0 bit -> sda_oe=0 immediately (asynchronously); all outputs at reset values; the next START/0x50 write works normally.
